// File: rtl/sram_port_initiator_if.sv
// sram_port_initiator_if
//   Groups the request stream, response stream and array pins of one
//   SRAM port initiator.
//   master modport: the initiator itself (takes requests, drives array pins).
//   slave modport : the requester / array side seen by the initiator.
//   Ports: none; clock and reset stay outside the interface.
interface sram_port_initiator_if #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 32
);
    localparam int NBYTE = WIDTH / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [S_INDEX-1:0]   req_addr;
    logic [NBYTE-1:0]     req_wmask;
    logic [WIDTH-1:0]     req_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH-1:0]     rsp_rdata;

    logic                 csb;
    logic                 web;
    logic [S_INDEX-1:0]   addr;
    logic [WIDTH-1:0]     din;
    logic [WIDTH-1:0]     dout;

    modport master (
        input  req_valid, req_we, req_addr, req_wmask, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata,
        input  rsp_ready,
        output csb, web, addr, din,
        input  dout
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wmask, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        output rsp_ready,
        input  csb, web, addr, din,
        output dout
    );
endinterface

// File: rtl/sram_port_initiator.sv
// sram_port_initiator
//   Converts a valid/ready request stream into the single-port array pin
//   protocol (active-low csb/web, data on dout one cycle after a read) and
//   returns read data on a valid/ready response channel. Partial byte-masked
//   writes become a read-modify-write because the array has no write mask.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - request, response and array pins (master modport)
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | ready for a request; reads/partial writes issue array read
//   ST_RD_CAP | array returns read data this cycle; capture dout
//   ST_RSP    | hold response until the consumer takes it
//   ST_RMW    | merge dout with masked write data and write it back
module sram_port_initiator #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_initiator_if.master bus
);
    localparam int NBYTE = WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CAP = 2'd1,
        ST_RSP    = 2'd2,
        ST_RMW    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [S_INDEX-1:0]   r_addr_q;
    logic [WIDTH-1:0]     r_wdata_q;
    logic [NBYTE-1:0]     r_wmask_q;
    logic [WIDTH-1:0]     r_rdata_q;

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_mask_full;
    logic                 w_mask_zero;
    logic [WIDTH-1:0]     w_merged;
    logic                 w_csb;
    logic                 w_web;
    logic [S_INDEX-1:0]   w_addr;
    logic [WIDTH-1:0]     w_din;

    // Gated with rst so the port looks busy while reset is held.
    assign w_req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_mask_full = &bus.req_wmask;
    assign w_mask_zero = ~|bus.req_wmask;

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < NBYTE; i++) begin
            w_merged[8*i +: 8] = r_wmask_q[i] ? r_wdata_q[8*i +: 8] : bus.dout[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_wmask_q <= '0;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr_q  <= bus.req_addr;
                r_wdata_q <= bus.req_wdata;
                r_wmask_q <= bus.req_wmask;
            end
            if (r_state == ST_RD_CAP) begin
                r_rdata_q <= bus.dout;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_csb       = 1'b1;
        w_web       = 1'b1;
        w_addr      = r_addr_q;
        w_din       = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr = bus.req_addr;
                    if (!bus.req_we) begin
                        w_csb       = 1'b0;
                        w_state_nxt = ST_RD_CAP;
                    end else if (w_mask_full) begin
                        // Posted write: no response, next request next cycle.
                        w_csb = 1'b0;
                        w_web = 1'b0;
                        w_din = bus.req_wdata;
                    end else if (!w_mask_zero) begin
                        // Fetch the old word so unmasked bytes can be preserved.
                        w_csb       = 1'b0;
                        w_state_nxt = ST_RMW;
                    end
                end
            end
            ST_RD_CAP: begin
                w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RMW: begin
                w_csb       = 1'b0;
                w_web       = 1'b0;
                w_din       = w_merged;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Reset must deselect the array immediately, not at the next edge.
        if (rst) begin
            w_csb = 1'b1;
            w_web = 1'b1;
            w_din = '0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == ST_RSP);
    assign bus.rsp_rdata = r_rdata_q;
    assign bus.csb       = w_csb;
    assign bus.web       = w_web;
    assign bus.addr      = w_addr;
    assign bus.din       = w_din;
endmodule
